fu_wb_arbiter: RTL and testbench
================================

Name: fu_wb_arbiter

Overview:
- Shares one scoreboard writeback port among several variable-latency result producers: load, store and FPU.
- Each producer pushes results into its own small FIFO.
- A round-robin arbiter drains the FIFO heads onto a single valid/ready writeback port.
- Sits between the execute-stage result outputs and the scoreboard. Lets the scoreboard write-port count shrink without stalling producers until their FIFO fills.

Parameters:
- NR_PORTS, 3, number of requesters. Index 0 = load, 1 = store, 2 = FPU.
- DEPTH, 2, entries per requester FIFO. Power of two, ≥ 2.
- DATA_W, 64, result width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- flush_i  in  1  synchronous flush of all buffered results
- req_valid_i  in  NR_PORTS  per-requester result valid
- req_ready_o  out  NR_PORTS  per-requester FIFO not full
- req_data_i  in  NR_PORTS x wb_req_t  per-requester {result[DATA_W], trans_id[TRANS_ID_BITS], exception_t}
- wb_valid_o  out  1  writeback entry presented
- wb_ready_i  in  1  scoreboard accepts entry
- wb_data_o  out  wb_req_t  selected entry
- wb_src_o  out  $clog2(NR_PORTS)  index of the granted requester

Behaviour:
- Reset (async, rst_i=1):
  - all FIFOs empty; rr pointer = NR_PORTS-1, so port 0 has first priority; lock = 0.
  - Outputs: wb_valid_o=0, wb_data_o=0, wb_src_o=0, req_ready_o=all 1.
  - Reset asserted mid-transfer drops every buffered entry immediately.
- Enqueue:
  - Entry written on req_valid_i[i] & req_ready_o[i].
  - req_ready_o[i] = !full[i], a function of registered state only. No combinational path from wb_ready_i.
  - A full FIFO refuses a push even in a cycle where it is being popped. No pass-through.
- Latency: no bypass. An entry pushed in cycle N is earliest visible on wb_valid_o in cycle N+1.
- Arbitration:
  - wb_valid_o = OR of !empty[i].
  - Grant goes to the first non-empty port searching from (rr+1) mod NR_PORTS upward, with wrap-around.
  - wb_data_o and wb_src_o show the granted FIFO head. wb_data_o = 0 when !wb_valid_o.
- Stability (AXI-style):
  - Once wb_valid_o=1 and wb_ready_i=0, set lock. While locked, grant, wb_data_o and wb_src_o are held.
  - New arrivals on other ports never preempt a presented entry.
  - lock clears on handshake.
- Handshake (wb_valid_o & wb_ready_i):
  - pop the granted FIFO; rr ← granted index; lock ← 0.
  - One pop per cycle at most. Back-to-back grants are allowed every cycle.
- Simultaneous push and pop on the same non-full FIFO: count unchanged, both take effect.
- FIFO pointers: read/write pointers are $clog2(DEPTH)+1 bits.
  - full = (MSBs differ & LSBs equal); empty = pointers equal.
  - Pointers wrap naturally.
- Flush (flush_i=1):
  - next cycle all FIFOs are empty, lock=0, rr=NR_PORTS-1.
  - Pushes and a handshake in the flush cycle are discarded.
  - wb_valid_o is still combinational in the flush cycle. The scoreboard ignores writeback during flush.
- Fairness: with all ports continuously non-empty and wb_ready_i=1, grants cycle 0,1,2,0,… No port waits more than NR_PORTS-1 handshakes.

Decomposition:
- ariane_pkg gets:
  - wb_req_t typedef: {logic [63:0] result; logic [TRANS_ID_BITS-1:0] trans_id; exception_t ex}.
  - constant NR_WB_REQ = 3.
- Sub-module wb_fifo:
  - parameter DEPTH; clk_i, rst_i, flush_i, push, pop, data in/out, full, empty.
  - instantiated NR_PORTS times via generate.
- Arbiter and lock logic live in the top module.

Test Plan:
- Single load result, trans_id=5, result=0xDEAD_BEEF, wb_ready_i=1. → wb_valid_o in the next cycle with trans_id 5 and wb_src_o=0. FIFO empty the following cycle.
- All three ports push one entry (trans_ids 1,2,3) in the same cycle, wb_ready_i=1. → wb order is src 0,1,2 on three consecutive cycles. Next grant after a new push on port 0 comes from port 0.
- Port 1 presented with wb_ready_i=0 for 4 cycles while port 0 pushes. → wb_src_o stays 1 and wb_data_o is stable. Port 1 is granted on handshake; port 0 follows.
- Push 2 entries into port 2 (DEPTH=2) with wb_ready_i=0. → req_ready_o[2]=0. A third push is refused with no data loss. After one handshake, req_ready_o[2]=1 the next cycle.
- Fill all FIFOs, then pulse flush_i. → the next cycle has wb_valid_o=0 and req_ready_o=3'b111. A subsequent push on port 2 gets the first grant after port 0's priority reset.
- Assert rst_i asynchronously mid-stream with wb_valid_o=1. → wb_valid_o and wb_data_o go 0 without a clock edge. Operation resumes cleanly after release.

Source files
------------

// File: rtl/fu_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fu_wb_arbiter_pkg
// Shared types for the functional-unit writeback arbiter. Each result producer
// (load, store, FPU) delivers a wb_req_t. The arbiter hands the same type to
// the scoreboard.
// -----------------------------------------------------------------------------
package fu_wb_arbiter_pkg;

  localparam int unsigned DATA_W        = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned NR_WB_REQ     = 3;  // 0 = load, 1 = store, 2 = FPU

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [DATA_W-1:0]        result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    exception_t               ex;
  } wb_req_t;

  // Index reached by stepping `offset` positions past `base`, wrapping at n.
  function automatic int unsigned rr_index(int unsigned base, int unsigned offset,
                                           int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Small per-requester result FIFO. It has no bypass path, so a pushed entry
// first appears on data_o in the following cycle. Flush empties the FIFO
// synchronously and discards any push or pop requested in the same cycle.
//
// Ports
//   clk_i, rst_i  clock, asynchronous active-high reset
//   flush_i       drop all entries at the next edge
//   push_i        write data_i (ignored while full)
//   pop_i         drop the head entry (ignored while empty)
//   data_i        entry to enqueue
//   data_o        head entry, only meaningful while !empty_o
//   full_o        no free slot; a push in this cycle is refused
//   empty_o       no entry stored
// -----------------------------------------------------------------------------
module wb_fifo
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    flush_i,
  input  logic    push_i,
  input  logic    pop_i,
  input  wb_req_t data_i,
  output wb_req_t data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  // The extra pointer MSB tells a full FIFO apart from an empty one when the
  // index bits match.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  wb_req_t          mem_q [DEPTH];
  logic             push_en, pop_en;

  assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // The FIFO refuses a push while full, even if it is popped in the same cycle.
  assign push_en = push_i & ~full_o & ~flush_i;
  assign pop_en  = pop_i & ~empty_o & ~flush_i;
  assign data_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its input from before the clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset. The pointers alone define which
  // entries are valid, and leaving the array unreset lets it map to plain
  // registers or RAM.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// fu_wb_arbiter
// Lets several variable-latency result producers share one scoreboard
// writeback port. Each producer pushes into its own wb_fifo. A round-robin
// arbiter presents one FIFO head at a time on a valid/ready port. A presented
// entry is held stable until the scoreboard accepts it (AXI-style).
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        drop every buffered result and reset the arbitration state
//   req_valid_i    per-requester result valid
//   req_ready_o    per-requester FIFO not full (depends on registered state only)
//   req_data_i     per-requester result entry
//   wb_valid_o     an entry is presented
//   wb_ready_i     scoreboard accepts the presented entry
//   wb_data_o      presented entry (zero when nothing is presented)
//   wb_src_o       index of the granted requester (zero when nothing presented)
// -----------------------------------------------------------------------------
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter  int unsigned NR_PORTS = NR_WB_REQ,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned SRC_W    = $clog2(NR_PORTS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic    [NR_PORTS-1:0]   req_valid_i,
  output logic    [NR_PORTS-1:0]   req_ready_o,
  input  wb_req_t [NR_PORTS-1:0]   req_data_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output wb_req_t                  wb_data_o,
  output logic    [SRC_W-1:0]      wb_src_o
);

  logic    [NR_PORTS-1:0] full, empty, pop;
  wb_req_t [NR_PORTS-1:0] head;

  // rr_q holds the most recently granted port. The search for the next grant
  // starts one position past it.
  logic [SRC_W-1:0] rr_q, rr_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic             lock_q, lock_d;
  logic [SRC_W-1:0] grant, grant_search, cand;
  logic             found, handshake;

  for (genvar i = 0; i < NR_PORTS; i++) begin : g_fifo
    wb_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (req_valid_i[i]),
      .pop_i   (pop[i]),
      .data_i  (req_data_i[i]),
      .data_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  assign req_ready_o = ~full;
  assign wb_valid_o  = |(~empty);
  assign handshake   = wb_valid_o & wb_ready_i;

  // Search for the first non-empty port after rr_q, with wrap-around.
  always_comb begin
    grant_search = rr_q;
    cand         = rr_q;
    found        = 1'b0;
    for (int unsigned k = 1; k <= NR_PORTS; k++) begin
      cand = SRC_W'(rr_index(32'(rr_q), k, NR_PORTS));
      if (!found && !empty[cand]) begin
        found        = 1'b1;
        grant_search = cand;
      end
    end
  end

  // While locked, the entry already presented stays in place. New arrivals
  // cannot preempt it.
  assign grant     = lock_q ? grant_q : grant_search;
  assign wb_data_o = wb_valid_o ? head[grant] : '0;
  assign wb_src_o  = wb_valid_o ? grant : '0;

  always_comb begin
    pop        = '0;
    pop[grant] = handshake;
  end

  always_comb begin
    rr_d    = rr_q;
    lock_d  = lock_q;
    grant_d = grant_q;
    if (flush_i) begin
      rr_d   = SRC_W'(NR_PORTS - 1);
      lock_d = 1'b0;
    end else if (handshake) begin
      rr_d   = grant;
      lock_d = 1'b0;
    end else if (wb_valid_o) begin
      lock_d  = 1'b1;
      grant_d = grant;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q    <= SRC_W'(NR_PORTS - 1);
      lock_q  <= 1'b0;
      grant_q <= '0;
    end else begin
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fu_wb_arbiter
// Directed scenarios with hand-derived expectations, then a randomized run
// checked against a queue-based behavioural model of the arbiter.
// -----------------------------------------------------------------------------
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  localparam int NP    = 3;
  localparam int DEPTH = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic    [NP-1:0] req_valid_i = '0;
  logic    [NP-1:0] req_ready_o;
  wb_req_t [NP-1:0] req_data_i = '0;
  logic             wb_valid_o;
  logic             wb_ready_i = 1'b0;
  wb_req_t          wb_data_o;
  logic    [1:0]    wb_src_o;

  int total = 0;
  int bad   = 0;

  // Behavioural model: one queue per port, the last granted port, and the
  // held grant while an entry waits for ready.
  wb_req_t mq [NP][$];
  int      m_rr;
  bit      m_lock;
  int      m_held;

  fu_wb_arbiter #(.NR_PORTS(NP), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (wb_ready_i),
    .wb_data_o   (wb_data_o),
    .wb_src_o    (wb_src_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  function automatic wb_req_t mk(int tid, logic [63:0] res);
    wb_req_t e;
    e          = '0;
    e.result   = res;
    e.trans_id = 3'(tid);
    return e;
  endfunction

  function automatic wb_req_t rand_entry();
    wb_req_t e;
    e.result   = {$urandom, $urandom};
    e.trans_id = 3'($urandom);
    e.ex.cause = {$urandom, $urandom};
    e.ex.tval  = {$urandom, $urandom};
    e.ex.valid = 1'($urandom);
    return e;
  endfunction

  function automatic int m_grant();
    if (m_lock) return m_held;
    for (int k = 1; k <= NP; k++) begin
      if (mq[(m_rr + k) % NP].size() > 0) return (m_rr + k) % NP;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    req_valid_i = '0;
    wb_ready_i  = 1'b0;
    for (int i = 0; i < NP; i++) mq[i].delete();
    m_rr   = NP - 1;
    m_lock = 1'b0;
    m_held = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", wb_valid_o); end
    total++; if (wb_data_o !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", wb_data_o); end
    total++; if (wb_src_o !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", wb_src_o); end
    total++; if (req_ready_o !== 3'b111) begin bad++; $display("FAIL reset_ready got=%b exp=111", req_ready_o); end
  endtask

  task automatic test_single_load();
    do_reset();
    req_valid_i   = 3'b001;
    req_data_i[0] = mk(5, 64'hDEAD_BEEF);
    wb_ready_i    = 1'b1;
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL single_no_bypass got=%b exp=0", wb_valid_o); end
    tick();
    req_valid_i = '0;
    #1;
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", wb_valid_o); end
    total++; if (wb_src_o !== 2'd0) begin bad++; $display("FAIL single_src got=%0d exp=0", wb_src_o); end
    total++; if (wb_data_o !== mk(5, 64'hDEAD_BEEF)) begin bad++; $display("FAIL single_data got=%h exp=%h", wb_data_o, mk(5, 64'hDEAD_BEEF)); end
    tick();
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_three_ports();
    do_reset();
    req_valid_i = 3'b111;
    for (int i = 0; i < NP; i++) req_data_i[i] = mk(i + 1, 64'(100 + i));
    wb_ready_i = 1'b1;
    tick();
    req_valid_i = '0;
    for (int k = 0; k < NP; k++) begin
      #1;
      total++; if (wb_src_o !== 2'(k)) begin bad++; $display("FAIL order_src%0d got=%0d exp=%0d", k, wb_src_o, k); end
      total++; if (wb_data_o !== mk(k + 1, 64'(100 + k))) begin bad++; $display("FAIL order_data%0d got=%h exp=%h", k, wb_data_o, mk(k + 1, 64'(100 + k))); end
      tick();
    end
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL order_drained got=%b exp=0", wb_valid_o); end
    req_valid_i   = 3'b001;
    req_data_i[0] = mk(4, 64'h44);
    tick();
    req_valid_i = '0;
    #1;
    total++; if (wb_src_o !== 2'd0 || wb_valid_o !== 1'b1) begin bad++; $display("FAIL order_wrap_src got=%0d/%b exp=0/1", wb_src_o, wb_valid_o); end
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    wb_ready_i    = 1'b0;
    req_valid_i   = 3'b010;
    req_data_i[1] = mk(7, 64'h77);
    tick();
    for (int k = 0; k < 4; k++) begin
      req_valid_i   = 3'b001;
      req_data_i[0] = mk(4 + k, 64'(k));
      #1;
      total++; if (wb_src_o !== 2'd1) begin bad++; $display("FAIL lock_src%0d got=%0d exp=1", k, wb_src_o); end
      total++; if (wb_data_o !== mk(7, 64'h77)) begin bad++; $display("FAIL lock_data%0d got=%h exp=%h", k, wb_data_o, mk(7, 64'h77)); end
      tick();
    end
    req_valid_i = '0;
    wb_ready_i  = 1'b1;
    #1;
    total++; if (wb_src_o !== 2'd1) begin bad++; $display("FAIL lock_release_src got=%0d exp=1", wb_src_o); end
    tick();
    #1;
    total++; if (wb_src_o !== 2'd0 || wb_data_o !== mk(4, 64'd0)) begin bad++; $display("FAIL lock_next0 got=%0d/%h exp=0/%h", wb_src_o, wb_data_o, mk(4, 64'd0)); end
    tick();
    #1;
    total++; if (wb_src_o !== 2'd0 || wb_data_o !== mk(5, 64'd1)) begin bad++; $display("FAIL lock_next1 got=%0d/%h exp=0/%h", wb_src_o, wb_data_o, mk(5, 64'd1)); end
    tick();
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL lock_drained got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_full();
    do_reset();
    wb_ready_i    = 1'b0;
    req_valid_i   = 3'b100;
    req_data_i[2] = mk(1, 64'h11);
    tick();
    req_data_i[2] = mk(2, 64'h22);
    tick();
    req_data_i[2] = mk(3, 64'h33);
    #1;
    total++; if (req_ready_o !== 3'b011) begin bad++; $display("FAIL full_ready got=%b exp=011", req_ready_o); end
    tick();
    req_valid_i = '0;
    #1;
    total++; if (req_ready_o !== 3'b011) begin bad++; $display("FAIL full_refused_ready got=%b exp=011", req_ready_o); end
    total++; if (wb_src_o !== 2'd2 || wb_data_o !== mk(1, 64'h11)) begin bad++; $display("FAIL full_head got=%0d/%h exp=2/%h", wb_src_o, wb_data_o, mk(1, 64'h11)); end
    wb_ready_i = 1'b1;
    tick();
    #1;
    total++; if (req_ready_o !== 3'b111) begin bad++; $display("FAIL full_ready_after_pop got=%b exp=111", req_ready_o); end
    total++; if (wb_data_o !== mk(2, 64'h22)) begin bad++; $display("FAIL full_second got=%h exp=%h", wb_data_o, mk(2, 64'h22)); end
    tick();
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL full_third_dropped got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_flush();
    do_reset();
    wb_ready_i    = 1'b1;
    req_valid_i   = 3'b010;
    req_data_i[1] = mk(1, 64'h1);
    tick();
    req_valid_i = '0;
    #1;
    total++; if (wb_src_o !== 2'd1) begin bad++; $display("FAIL flush_pre_src got=%0d exp=1", wb_src_o); end
    tick();
    wb_ready_i  = 1'b0;
    req_valid_i = 3'b111;
    for (int i = 0; i < NP; i++) req_data_i[i] = mk(i, 64'(i));
    tick();
    tick();
    #1;
    total++; if (req_ready_o !== 3'b000) begin bad++; $display("FAIL flush_filled got=%b exp=000", req_ready_o); end
    flush_i    = 1'b1;
    wb_ready_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    req_valid_i = '0;
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", wb_valid_o); end
    total++; if (req_ready_o !== 3'b111) begin bad++; $display("FAIL flush_ready got=%b exp=111", req_ready_o); end
    req_valid_i   = 3'b101;
    req_data_i[0] = mk(2, 64'h2);
    req_data_i[2] = mk(3, 64'h3);
    tick();
    req_valid_i = '0;
    #1;
    total++; if (wb_src_o !== 2'd0 || wb_data_o !== mk(2, 64'h2)) begin bad++; $display("FAIL flush_rr_reset got=%0d/%h exp=0/%h", wb_src_o, wb_data_o, mk(2, 64'h2)); end
    tick();
    #1;
    total++; if (wb_src_o !== 2'd2 || wb_data_o !== mk(3, 64'h3)) begin bad++; $display("FAIL flush_port2 got=%0d/%h exp=2/%h", wb_src_o, wb_data_o, mk(3, 64'h3)); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    wb_ready_i  = 1'b0;
    req_valid_i = 3'b111;
    for (int i = 0; i < NP; i++) req_data_i[i] = mk(i + 2, 64'(i + 9));
    tick();
    req_valid_i = '0;
    #1;
    total++; if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL areset_pre_valid got=%b exp=1", wb_valid_o); end
    #1;
    rst_i = 1'b1;
    #1;
    total++; if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", wb_valid_o); end
    total++; if (wb_data_o !== '0) begin bad++; $display("FAIL areset_data got=%h exp=0", wb_data_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++; if (req_ready_o !== 3'b111) begin bad++; $display("FAIL areset_ready got=%b exp=111", req_ready_o); end
    req_valid_i   = 3'b010;
    req_data_i[1] = mk(6, 64'h66);
    wb_ready_i    = 1'b1;
    tick();
    req_valid_i = '0;
    #1;
    total++; if (wb_src_o !== 2'd1 || wb_data_o !== mk(6, 64'h66)) begin bad++; $display("FAIL areset_resume got=%0d/%h exp=1/%h", wb_src_o, wb_data_o, mk(6, 64'h66)); end
    tick();
  endtask

  task automatic test_random();
    int          g;
    logic        exp_valid;
    logic [1:0]  exp_src;
    wb_req_t     exp_data;
    logic [2:0]  exp_ready;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_valid_i = 3'($urandom);
      for (int i = 0; i < NP; i++) req_data_i[i] = rand_entry();
      wb_ready_i = ($urandom_range(0, 9) < 6);
      flush_i    = ($urandom_range(0, 39) == 0);
      #1;
      g         = m_grant();
      exp_valid = (g >= 0);
      exp_src   = exp_valid ? 2'(g) : 2'd0;
      exp_data  = exp_valid ? mq[g][0] : '0;
      for (int i = 0; i < NP; i++) exp_ready[i] = (mq[i].size() < DEPTH);
      total++; if (wb_valid_o !== exp_valid) begin bad++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, wb_valid_o, exp_valid); end
      total++; if (wb_src_o !== exp_src) begin bad++; $display("FAIL rand_src c=%0d got=%0d exp=%0d", c, wb_src_o, exp_src); end
      total++; if (wb_data_o !== exp_data) begin bad++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, wb_data_o, exp_data); end
      total++; if (req_ready_o !== exp_ready) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready_o, exp_ready); end
      if (flush_i) begin
        for (int i = 0; i < NP; i++) mq[i].delete();
        m_rr   = NP - 1;
        m_lock = 1'b0;
      end else begin
        if (exp_valid && wb_ready_i) begin
          void'(mq[g].pop_front());
          m_rr   = g;
          m_lock = 1'b0;
        end else if (exp_valid) begin
          m_lock = 1'b1;
          m_held = g;
        end
        for (int i = 0; i < NP; i++)
          if (req_valid_i[i] && exp_ready[i]) mq[i].push_back(req_data_i[i]);
      end
      tick();
    end
    flush_i     = 1'b0;
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_three_ports();
    test_lock();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
